// File: rtl/mc10_vdg_fetch.sv
// MC-10 VDG feeder: arbitrates one video/system RAM between CPU and display
// fetches, and holds the $BFxx video control latch.
module mc10_vdg_fetch #(
    parameter int          RAM_AW   = 13,
    parameter logic [15:0] RAM_BASE = 16'h4000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [12:0]       videoaddr,
    output logic [7:0]        vdg_dd,
    output logic              an_s,
    output logic              inv,
    output logic              an_g,
    output logic [2:0]        gm,
    output logic              css,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_ack,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout
);

    typedef enum logic [2:0] {
        IDLE, VRD, VWAIT, CRD, CWAIT, CWR
    } state_t;

    localparam logic [16:0] RAM_LIM = {1'b0, RAM_BASE} + (17'd1 << RAM_AW);

    state_t            state, state_n;
    logic [RAM_AW-1:0] vaddr, last_vaddr, ram_idx;
    logic              ctrl_hit, ram_hit, vdg_pend, req_ok;
    logic              v_issue, c_issue, bypass, we_q;

    assign vaddr    = RAM_AW'(videoaddr);
    assign ram_idx  = RAM_AW'(cpu_addr - RAM_BASE);
    assign ctrl_hit = (cpu_addr[15:8] == 8'hBF);
    assign ram_hit  = !ctrl_hit
                   && ({1'b0, cpu_addr} >= {1'b0, RAM_BASE})
                   && ({1'b0, cpu_addr} < RAM_LIM);
    assign vdg_pend = (vaddr != last_vaddr);
    // The ack cycle belongs to the request just finished.
    assign req_ok   = cpu_req && !cpu_ack;
    // Gated by reset so an aborted write never reaches the RAM.
    assign ram_we   = we_q && !reset;

    always_comb begin
        state_n = state;
        v_issue = 1'b0;
        c_issue = 1'b0;
        bypass  = 1'b0;
        unique case (state)
            IDLE: begin
                if (vdg_pend) begin
                    v_issue = 1'b1;
                    state_n = VRD;
                end else if (req_ok && ram_hit) begin
                    c_issue = 1'b1;
                    state_n = cpu_we ? CWR : CRD;
                end else if (req_ok) begin
                    bypass = 1'b1;
                end
            end
            VRD:     state_n = VWAIT;
            VWAIT:   state_n = IDLE;
            CRD:     state_n = CWAIT;
            CWAIT:   state_n = IDLE;
            CWR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_vaddr <= '1;
            vdg_dd     <= 8'h00;
            an_s       <= 1'b0;
            inv        <= 1'b0;
            an_g       <= 1'b0;
            gm         <= 3'b000;
            css        <= 1'b0;
            cpu_dout   <= 8'h00;
            cpu_ack    <= 1'b0;
            ram_addr   <= '0;
            we_q       <= 1'b0;
            ram_din    <= 8'h00;
        end else begin
            state   <= state_n;
            cpu_ack <= 1'b0;
            we_q    <= 1'b0;
            if (v_issue) begin
                ram_addr   <= vaddr;
                last_vaddr <= vaddr;
            end
            if (c_issue) begin
                ram_addr <= ram_idx;
                if (cpu_we) begin
                    we_q    <= 1'b1;
                    ram_din <= cpu_din;
                end
            end
            if (state == VWAIT) begin
                vdg_dd <= ram_dout;
                an_s   <= ram_dout[7];
                inv    <= ram_dout[6];
            end
            if (state == CWAIT) begin
                cpu_dout <= ram_dout;
                cpu_ack  <= 1'b1;
            end
            if (state == CWR) begin
                cpu_ack <= 1'b1;
            end
            if (bypass) begin
                cpu_ack <= 1'b1;
                if (ctrl_hit) begin
                    if (cpu_we) begin
                        css  <= cpu_din[6];
                        an_g <= cpu_din[5];
                        gm   <= cpu_din[4:2];
                    end else begin
                        cpu_dout <= {1'b0, css, an_g, gm, 2'b00};
                    end
                end else if (!cpu_we) begin
                    cpu_dout <= 8'hFF;
                end
            end
        end
    end

endmodule

// File: doc/mc10_vdg_fetch.md
Name: mc10_vdg_fetch

Overview:
Upstream feeder for the MC-10 VDG wrapper. It arbitrates one synchronous single-port video/system RAM between the 6803 CPU bus and VDG display fetches, and returns display bytes on dd. It also holds the $BFxx video control latch (an_g, gm, css) and decodes per-byte attributes (an_s, inv) from the fetched byte.

Parameters:
RAM_AW, 13, RAM word-address width; RAM depth is 2**RAM_AW bytes.
RAM_BASE, 16'h4000, CPU address of RAM byte 0.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
videoaddr  in  13  VDG display address
vdg_dd  out  8  fetched display byte, to VDG dd
an_s  out  1  vdg_dd[7] of the current byte
inv  out  1  vdg_dd[6] of the current byte
an_g  out  1  control latch bit 5
gm  out  3  control latch bits 4:2
css  out  1  control latch bit 6
cpu_req  in  1  CPU access request, held until ack
cpu_we  in  1  1 = write
cpu_addr  in  16  CPU byte address
cpu_din  in  8  CPU write data
cpu_dout  out  8  read data, valid on the cpu_ack cycle
cpu_ack  out  1  one-cycle completion pulse
ram_addr  out  RAM_AW  RAM address
ram_we  out  1  RAM write strobe
ram_din  out  8  RAM write data
ram_dout  in  8  RAM read data, 1-cycle latency

Behaviour:
- Reset values: vdg_dd=0, an_s=0, inv=0, an_g=0, gm=0, css=0, cpu_dout=0, cpu_ack=0, ram_we=0, ram_addr=0, ram_din=0. FSM goes to IDLE. last_vaddr is set to all-ones so the first cycle after reset triggers a fetch.
- Address decode:
  - Control hit: cpu_addr[15:8]==8'hBF.
  - RAM hit: RAM_BASE <= cpu_addr < RAM_BASE + 2**RAM_AW. RAM index = cpu_addr - RAM_BASE, truncated to RAM_AW bits.
  - Any other address is a miss.
- Control latch:
  - Control-hit write: acks the cycle after the request is seen, with no RAM access.
  - Latch update: css<=cpu_din[6], an_g<=cpu_din[5], gm<=cpu_din[4:2].
  - Control-hit read: returns {1'b0, css, an_g, gm, 2'b00}.
  - Miss read: returns 8'hFF and acks the next cycle. Miss write: acks the next cycle, no side effects.
- vdg_pend:
  - Set when videoaddr != last_vaddr (videoaddr zero-extended or truncated to RAM_AW bits).
  - Cleared when a VDG fetch issues; last_vaddr<=videoaddr at the same time.
- FSM states: IDLE, VRD, VWAIT, CRD, CWAIT, CWR.
  - IDLE:
    - If vdg_pend: ram_addr<=videoaddr, go to VRD.
    - Else if a cpu_req RAM hit is pending: ram_addr<=index. Write goes to CWR with ram_we=1 and ram_din=cpu_din. Read goes to CRD.
    - VDG has strict priority over the CPU.
  - VRD -> VWAIT: RAM latency cycle.
  - VWAIT:
    - vdg_dd<=ram_dout, an_s<=ram_dout[7], inv<=ram_dout[6].
    - Go to IDLE.
  - CRD -> CWAIT: RAM latency cycle.
  - CWAIT: cpu_dout<=ram_dout, cpu_ack=1, go to IDLE.
  - CWR: the RAM write occurs this cycle. ram_we deasserts next cycle; cpu_ack=1; go to IDLE.
- Latency:
  - Display: videoaddr change to vdg_dd update is 3 clocks (IDLE, VRD, VWAIT).
  - CPU read: 3 clocks when the VDG is idle.
  - A CPU access already in progress always completes; the VDG waits for it, worst case 3 clocks of extra delay.
- Control access vs RAM arbitration: control accesses bypass the RAM FSM, but only ack while the FSM is in IDLE and no VDG fetch is issuing that cycle.
- CPU handshake:
  - Exactly one cpu_ack per request. The CPU drops cpu_req on the ack cycle.
  - cpu_req still high the cycle after ack is treated as a new request.
- videoaddr changing again mid-fetch: the in-flight fetch completes with the old address. vdg_pend re-sets and the new address fetches next; no byte is dropped for the latest address.
- Reset mid-operation:
  - FSM returns to IDLE and ram_we drops the same cycle; no partial write persists past the reset cycle.
  - No ack is issued for the aborted access.

Test Plan:
- Reset, hold videoaddr=13'h0000, preload RAM[0]=8'hC5 -> vdg_dd=8'hC5, an_s=1, inv=1 three clocks after reset release.
- CPU write 8'h64 to 16'hBFFF -> cpu_ack next cycle; css=1, an_g=1, gm=3'b001; RAM untouched. Read 16'hBFFF -> cpu_dout=8'h64.
- CPU write 8'hA5 to 16'h4010, then read 16'h4010 with videoaddr static -> ram_we pulsed once at address 13'h0010; read acks 3 clocks after request with cpu_dout=8'hA5.
- videoaddr change and CPU read 16'h4020 in the same cycle -> VDG fetch issues first; cpu_ack arrives 6 clocks after request; both data values are correct.
- Read 16'h0100 (miss) -> cpu_dout=8'hFF, ack next cycle. Write 16'h0100 -> ack, ram_we never asserted.
- Assert reset during CWR -> ram_we=0 the next cycle, no cpu_ack, all outputs at reset values.
